// File: rtl/riscv_pkg.sv
// Shared fetch-path types: controller state encoding and the buffered fetch entry.
// The entry PC field is sized for the widest supported address; users cast to their own width.
package riscv_pkg;

  localparam int PC_MAX_W = 62;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    logic [31:0]         insn;
    logic                err;
  } fetch_entry_t;

endpackage

// File: rtl/insn_fetch_buf.sv
// Synchronous DEPTH-entry FIFO of fetch entries with flush; push visible at head the cycle after.
// Push while full without a same-cycle pop is dropped; flush overrides push and pop.
module insn_fetch_buf
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  fetch_entry_t             i_push_dat,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [$clog2(DEPTH):0]   o_count,
  output fetch_entry_t             o_head
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [PW:0]   r_count;
  fetch_entry_t  r_mem [DEPTH];

  logic w_do_pop;
  logic w_do_push;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != (PW+1)'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_push_dat;
        r_wr        <= r_wr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd <= r_rd + PW'(1);
      end
      r_count <= r_count + (PW+1)'(w_do_push) - (PW+1)'(w_do_pop);
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];

endmodule

// File: rtl/insn_fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request, responses buffered for decode.
// Response-to-decode latency one cycle; requests stall while the buffer is full or a fault halts fetch.
module insn_fetch_ctrl
  import riscv_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-3:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [31:0]           mem_rsp_data,
  input  logic                  mem_rsp_err,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-3:0] redirect_pc,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [ADDR_WIDTH-3:0] dec_pc,
  output logic [31:0]           dec_insn,
  output logic                  dec_err
);

  localparam int PC_W = ADDR_WIDTH - 2;
  localparam int CW   = $clog2(BUF_DEPTH) + 1;

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] r_req_pc;

  logic            w_hs;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_count;
  fetch_entry_t    w_push_dat;
  fetch_entry_t    w_head;

  assign mem_req_valid = !rst && (r_state == S_REQ) && (w_count < CW'(BUF_DEPTH));
  assign mem_req_addr  = r_pc;
  assign w_hs          = mem_req_valid && mem_req_ready;

  assign dec_valid = (w_count != '0);
  assign w_pop     = dec_valid && dec_ready;
  assign dec_pc    = PC_W'(w_head.pc);
  assign dec_insn  = w_head.insn;
  assign dec_err   = w_head.err;

  assign w_push_dat = '{pc: PC_MAX_W'(r_req_pc), insn: mem_rsp_data, err: mem_rsp_err};

  // A redirect always retargets the PC; what happens to an in-flight request depends on state.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    case (r_state)
      S_REQ: begin
        if (redirect_valid) begin
          w_state_nxt = w_hs ? S_DRAIN : S_REQ;
          w_pc_nxt    = redirect_pc;
        end else if (w_hs) begin
          w_state_nxt = S_WAIT;
          w_pc_nxt    = r_pc + PC_W'(1);
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          w_state_nxt = mem_rsp_valid ? S_REQ : S_DRAIN;
          w_pc_nxt    = redirect_pc;
        end else if (mem_rsp_valid) begin
          w_push      = 1'b1;
          w_state_nxt = mem_rsp_err ? S_HALT : S_REQ;
        end
      end
      S_DRAIN: begin
        if (redirect_valid) begin
          w_pc_nxt = redirect_pc;
        end
        if (mem_rsp_valid) begin
          w_state_nxt = S_REQ;
        end
      end
      S_HALT: begin
        if (redirect_valid) begin
          w_state_nxt = S_REQ;
          w_pc_nxt    = redirect_pc;
        end
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_REQ;
      r_pc     <= RESET_PC[ADDR_WIDTH-1:2];
      r_req_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_hs) begin
        r_req_pc <= r_pc;
      end
    end
  end

  insn_fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .i_flush    (redirect_valid),
    .o_count    (w_count),
    .o_head     (w_head)
  );

endmodule
